// File: rtl/bus_arbiter_mux_pkg.sv
// Shared types and constants for the round-robin bus arbiter and its picker.
// Legacy source indices keep the old 5-bit select code assignments.
package bus_arb_pkg;

  typedef enum logic {
    IDLE,
    OWNED
  } state_t;

  localparam int unsigned DEF_WIDTH    = 32;
  localparam int unsigned DEF_NUM_SRC  = 24;
  localparam int unsigned DEF_MAX_HOLD = 8;

  localparam int unsigned R0     = 0;
  localparam int unsigned R1     = 1;
  localparam int unsigned R2     = 2;
  localparam int unsigned R3     = 3;
  localparam int unsigned R4     = 4;
  localparam int unsigned R5     = 5;
  localparam int unsigned R6     = 6;
  localparam int unsigned R7     = 7;
  localparam int unsigned R8     = 8;
  localparam int unsigned R9     = 9;
  localparam int unsigned R10    = 10;
  localparam int unsigned R11    = 11;
  localparam int unsigned R12    = 12;
  localparam int unsigned R13    = 13;
  localparam int unsigned R14    = 14;
  localparam int unsigned R15    = 15;
  localparam int unsigned HI     = 16;
  localparam int unsigned LO     = 17;
  localparam int unsigned ZHI    = 18;
  localparam int unsigned ZLO    = 19;
  localparam int unsigned PC     = 20;
  localparam int unsigned MDR    = 21;
  localparam int unsigned INPORT = 22;
  localparam int unsigned C      = 23;

endpackage

// File: rtl/bus_arbiter_mux_rr_pick.sv
// Combinational round-robin picker: first set req bit at or above ptr, wrapping.
// Searches {req, req & mask(>=ptr)} for its lowest set bit and folds the index back.
module rr_pick #(
  parameter int unsigned NUM_SRC = 24,
  parameter int unsigned SEL_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic               pick_valid,
  output logic [SEL_W-1:0]   pick_idx
);

  localparam int unsigned IDX_W = $clog2(2 * NUM_SRC);

  logic [NUM_SRC-1:0]   upper_mask;
  logic [2*NUM_SRC-1:0] search;
  logic [IDX_W-1:0]     found;

  always_comb begin
    upper_mask = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      upper_mask[i] = (i >= 32'(ptr));
    end
    search = {req, req & upper_mask};
  end

  // Scan downward so the lowest set bit is the last one written.
  always_comb begin
    found = '0;
    for (int unsigned i = 2 * NUM_SRC; i > 0; i--) begin
      if (search[i-1]) begin
        found = IDX_W'(i - 1);
      end
    end
  end

  always_comb begin
    pick_valid = |req;
    if (found >= IDX_W'(NUM_SRC)) begin
      pick_idx = SEL_W'(found - IDX_W'(NUM_SRC));
    end else begin
      pick_idx = SEL_W'(found);
    end
  end

endmodule

// File: rtl/bus_arbiter_mux.sv
// Round-robin arbitrated bus driver with registered grant and bus keeper.
// Optional contention counter output enabled by defining BUS_ARB_STATS_EN.
module bus_arbiter_mux
  import bus_arb_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned NUM_SRC  = DEF_NUM_SRC,
  parameter int unsigned SEL_W    = $clog2(NUM_SRC),
  parameter int unsigned MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic [NUM_SRC-1:0]       req,
  input  logic                     lock,
  input  logic [NUM_SRC*WIDTH-1:0] src_data,
  output logic [NUM_SRC-1:0]       grant,
  output logic                     grant_valid,
  output logic [SEL_W-1:0]         grant_idx,
  output logic [WIDTH-1:0]         bus_out,
  output logic                     contention
`ifdef BUS_ARB_STATS_EN
  ,
  output logic [15:0]              contention_cnt
`endif
);

  localparam int unsigned HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  localparam logic [SEL_W-1:0]  LAST_SRC  = SEL_W'(NUM_SRC - 1);

  state_t             state;
  logic [SEL_W-1:0]   ptr;
  logic [HOLD_W-1:0]  hold_cnt;

  logic               pick_valid;
  logic [SEL_W-1:0]   pick_idx;
  logic [WIDTH-1:0]   src_arr [NUM_SRC];
  logic               owner_req;
  logic               rotate_due;
  logic               multi_req;
  logic               issue;
  logic               drop;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_unpack
    assign src_arr[g] = src_data[g*WIDTH +: WIDTH];
  end

  rr_pick #(
    .NUM_SRC (NUM_SRC),
    .SEL_W   (SEL_W)
  ) u_pick (
    .req        (req),
    .ptr        (ptr),
    .pick_valid (pick_valid),
    .pick_idx   (pick_idx)
  );

  assign owner_req  = req[grant_idx];
  assign rotate_due = !lock && (hold_cnt == HOLD_LAST);
  assign multi_req  = |(req & (req - NUM_SRC'(1)));

  // ptr sits at owner+1, so a rotation pick equal to the owner means nobody else asked.
  always_comb begin
    issue = 1'b0;
    drop  = 1'b0;
    case (state)
      IDLE: begin
        issue = pick_valid;
      end
      OWNED: begin
        if (!owner_req) begin
          issue = pick_valid;
          drop  = !pick_valid;
        end else if (rotate_due && (pick_idx != grant_idx)) begin
          issue = 1'b1;
        end
      end
      default: begin
        issue = 1'b0;
        drop  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state       <= IDLE;
      ptr         <= '0;
      hold_cnt    <= '0;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_idx   <= '0;
      bus_out     <= '0;
      contention  <= 1'b0;
    end else begin
      contention <= multi_req;
      if (issue) begin
        state       <= OWNED;
        grant       <= NUM_SRC'(1) << pick_idx;
        grant_valid <= 1'b1;
        grant_idx   <= pick_idx;
        bus_out     <= src_arr[pick_idx];
        hold_cnt    <= '0;
        ptr         <= (pick_idx == LAST_SRC) ? '0 : pick_idx + SEL_W'(1);
      end else if (drop) begin
        state       <= IDLE;
        grant       <= '0;
        grant_valid <= 1'b0;
      end else if (state == OWNED) begin
        bus_out <= src_arr[grant_idx];
        if (rotate_due) begin
          hold_cnt <= '0;
        end else if (hold_cnt != HOLD_LAST) begin
          hold_cnt <= hold_cnt + HOLD_W'(1);
        end
      end
    end
  end

`ifdef BUS_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (clr) begin
      contention_cnt <= '0;
    end else if (multi_req && (contention_cnt != '1)) begin
      contention_cnt <= contention_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bus_arbiter_mux.sv
// Directed and randomized checks of bus_arbiter_mux against a behavioural model.
module tb_bus_arbiter_mux;

  localparam int WIDTH    = 32;
  localparam int NUM_SRC  = 24;
  localparam int SEL_W    = 5;
  localparam int MAX_HOLD = 4;

  logic                     clk;
  logic                     clr;
  logic [NUM_SRC-1:0]       req;
  logic                     lock;
  logic [NUM_SRC*WIDTH-1:0] src_data;
  logic [NUM_SRC-1:0]       grant;
  logic                     grant_valid;
  logic [SEL_W-1:0]         grant_idx;
  logic [WIDTH-1:0]         bus_out;
  logic                     contention;
`ifdef BUS_ARB_STATS_EN
  logic [15:0]              contention_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          m_owner;
  int          m_idx;
  int          m_ptr;
  int          m_hold;
  logic [31:0] m_bus;
  logic        m_cont;
  int          m_cnt;

  bus_arbiter_mux #(
    .WIDTH    (WIDTH),
    .NUM_SRC  (NUM_SRC),
    .SEL_W    (SEL_W),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk         (clk),
    .clr         (clr),
    .req         (req),
    .lock        (lock),
    .src_data    (src_data),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx),
    .bus_out     (bus_out),
    .contention  (contention)
`ifdef BUS_ARB_STATS_EN
    ,
    .contention_cnt (contention_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] src_word(input int i);
    return src_data[i*WIDTH +: WIDTH];
  endfunction

  function automatic int m_pick(input logic [NUM_SRC-1:0] r, input int from);
    for (int j = 0; j < NUM_SRC; j++) begin
      if (r[(from + j) % NUM_SRC]) return (from + j) % NUM_SRC;
    end
    return -1;
  endfunction

  function automatic int popcount(input logic [NUM_SRC-1:0] r);
    int n = 0;
    for (int j = 0; j < NUM_SRC; j++) n += int'(r[j]);
    return n;
  endfunction

  task automatic m_grant(input int p);
    m_owner = p;
    m_idx   = p;
    m_hold  = 0;
    m_ptr   = (p + 1) % NUM_SRC;
    m_bus   = src_word(p);
  endtask

  // Applies the arbitration rules to the inputs present at the coming edge.
  task automatic model_step();
    int p;
    if (clr) begin
      m_owner = -1; m_idx = 0; m_ptr = 0; m_hold = 0;
      m_bus = '0; m_cont = 1'b0; m_cnt = 0;
    end else begin
      m_cont = (popcount(req) > 1);
      if (m_cont && m_cnt < 65535) m_cnt++;
      p = m_pick(req, m_ptr);
      if (m_owner < 0) begin
        if (p >= 0) m_grant(p);
      end else if (!req[m_owner]) begin
        if (p >= 0) m_grant(p);
        else m_owner = -1;
      end else if (!lock && m_hold == MAX_HOLD - 1 && p != m_owner) begin
        m_grant(p);
      end else begin
        if (!lock && m_hold == MAX_HOLD - 1) m_hold = 0;
        else if (m_hold < MAX_HOLD - 1) m_hold++;
        m_bus = src_word(m_owner);
      end
    end
  endtask

  task automatic cycle();
    logic [63:0] eg;
    model_step();
    @(posedge clk);
    #1;
    eg = (m_owner >= 0) ? (64'd1 << m_owner) : 64'd0;
    chk("m_grant", 64'(grant), eg);
    chk("m_grant_valid", 64'(grant_valid), 64'(m_owner >= 0));
    chk("m_grant_idx", 64'(grant_idx), 64'(m_idx));
    chk("m_bus_out", 64'(bus_out), 64'(m_bus));
    chk("m_contention", 64'(contention), 64'(m_cont));
`ifdef BUS_ARB_STATS_EN
    chk("m_contention_cnt", 64'(contention_cnt), 64'(m_cnt));
`endif
  endtask

  task automatic randomize_src();
    for (int i = 0; i < NUM_SRC; i++) src_data[i*WIDTH +: WIDTH] = $urandom();
  endtask

  initial begin
    m_owner = -1; m_idx = 0; m_ptr = 0; m_hold = 0;
    m_bus = '0; m_cont = 1'b0; m_cnt = 0;

    // 1. Reset with every source requesting
    clr = 1'b1; lock = 1'b0; req = '1;
    randomize_src();
    cycle();
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_valid", 64'(grant_valid), 64'd0);
    chk("rst_idx", 64'(grant_idx), 64'd0);
    chk("rst_bus", 64'(bus_out), 64'd0);
    chk("rst_contention", 64'(contention), 64'd0);
    clr = 1'b0; req = '0;
    cycle();

    // 2. Single owner, then bus keeper
    src_data[5*WIDTH +: WIDTH] = 32'hDEADBEEF;
    req = NUM_SRC'(1) << 5;
    cycle();
    chk("s2_grant", 64'(grant), 64'h20);
    chk("s2_idx", 64'(grant_idx), 64'd5);
    chk("s2_bus", 64'(bus_out), 64'hDEADBEEF);
    req = '0;
    src_data[5*WIDTH +: WIDTH] = 32'h12345678;
    cycle();
    chk("s2_release_valid", 64'(grant_valid), 64'd0);
    chk("s2_keeper_bus", 64'(bus_out), 64'hDEADBEEF);

    // 3. Round-robin from ptr=0, then wrap from ptr=23
    clr = 1'b1; cycle(); clr = 1'b0;
    req = (NUM_SRC'(1) << 2) | (NUM_SRC'(1) << 7);
    cycle();
    chk("s3_first_idx", 64'(grant_idx), 64'd2);
    chk("s3_contention", 64'(contention), 64'd1);
    req = NUM_SRC'(1) << 7;
    cycle();
    chk("s3_handoff_idx", 64'(grant_idx), 64'd7);
    req = NUM_SRC'(1) << 2;
    cycle();
    chk("s3_back_idx", 64'(grant_idx), 64'd2);
    req = NUM_SRC'(1) << 22;
    cycle();
    chk("s3_pre_wrap_idx", 64'(grant_idx), 64'd22);
    req = NUM_SRC'(1) | (NUM_SRC'(1) << 23);
    cycle();
    chk("s3_wrap_idx", 64'(grant_idx), 64'd23);

    // 4. Forced rotation every MAX_HOLD cycles
    clr = 1'b1; cycle(); clr = 1'b0;
    req = (NUM_SRC'(1) << 3) | (NUM_SRC'(1) << 9);
    for (int c = 0; c < 12; c++) begin
      randomize_src();
      cycle();
      chk("s4_rotation_idx", 64'(grant_idx), ((c / MAX_HOLD) % 2 == 1) ? 64'd9 : 64'd3);
    end

    // 5. Lock holds the owner, unlock rotates immediately
    clr = 1'b1; cycle(); clr = 1'b0;
    lock = 1'b1;
    for (int c = 0; c < 20; c++) begin
      cycle();
      chk("s5_lock_idx", 64'(grant_idx), 64'd3);
      chk("s5_lock_contention", 64'(contention), 64'd1);
    end
    lock = 1'b0;
    cycle();
    chk("s5_unlock_idx", 64'(grant_idx), 64'd9);

    // 6. Reset while source 9 owns the bus
    clr = 1'b1;
    cycle();
    chk("s6_grant", 64'(grant), 64'd0);
    chk("s6_valid", 64'(grant_valid), 64'd0);
    chk("s6_idx", 64'(grant_idx), 64'd0);
    chk("s6_bus", 64'(bus_out), 64'd0);
    chk("s6_contention", 64'(contention), 64'd0);
    clr = 1'b0;
    req = NUM_SRC'(1) | (NUM_SRC'(1) << 9);
    cycle();
    chk("s6_after_idx", 64'(grant_idx), 64'd0);

    // Randomized traffic checked against the model every cycle
    for (int c = 0; c < 400; c++) begin
      randomize_src();
      if ($urandom_range(0, 3) == 0) req = NUM_SRC'($urandom() & $urandom());
      if ($urandom_range(0, 9) == 0) req = '0;
      lock = ($urandom_range(0, 3) == 0);
      clr  = ($urandom_range(0, 63) == 0);
      cycle();
    end
    clr = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
